// File: rtl/sd_pkg.sv
// Shared SD-over-SPI definitions used by the sector write and read blocks.
package sd_pkg;

  localparam int RESP_TIMEOUT_DEF = 255;
  localparam int BUSY_TIMEOUT_DEF = 65535;
  localparam int RAM_DEPTH_DEF    = 512;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_R1_WAIT, ST_GAP, ST_TOKEN, ST_DATA,
    ST_CRC, ST_DRESP, ST_BUSY, ST_DONE, ST_ERROR
  } sd_state_e;

  localparam logic [7:0] CMD24       = 8'h58;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam logic [4:0] DATA_ACCEPT = 5'h05;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_R1_TIMEOUT   = 3'd1;
  localparam logic [2:0] ERR_R1           = 3'd2;
  localparam logic [2:0] ERR_DATA_REJ     = 3'd3;
  localparam logic [2:0] ERR_BUSY_TIMEOUT = 3'd4;

  // Six-byte CMD24 frame; the CRC slot is a dummy 0xFF (CRC off in SPI mode).
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] addr);
    case (idx)
      3'd0:    cmd_byte = CMD24;
      3'd1:    cmd_byte = addr[31:24];
      3'd2:    cmd_byte = addr[23:16];
      3'd3:    cmd_byte = addr[15:8];
      3'd4:    cmd_byte = addr[7:0];
      default: cmd_byte = FILL_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/sd_write_if.sv
// Host command/status and source-RAM read port of the SD sector writer.
interface sd_write_if #(parameter int RAM_DEPTH = 512);
  logic [31:0]                    addr_in;
  logic                           write_en;
  logic                           busy;
  logic                           done;
  logic                           error;
  logic [2:0]                     err_code;
  logic [$clog2(RAM_DEPTH)-1:0]   ram_addr;
  logic [7:0]                     ram_dout;
  logic                           ram_en;

  modport master (
    output addr_in, write_en, ram_dout,
    input  busy, done, error, err_code, ram_addr, ram_en
  );

  modport slave (
    input  addr_in, write_en, ram_dout,
    output busy, done, error, err_code, ram_addr, ram_en
  );
endinterface

// File: rtl/spi_con.sv
// Byte-level SPI master, mode 0, SCLK = clk/2. One trigger pulse shifts one word;
// valid pulses for one cycle with the received word.
module spi_con #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  miso,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sclk,
  output logic                  mosi
);
  localparam int CW = $clog2(DATA_WIDTH);

  logic                  active_q, active_d;
  logic                  phase_q, phase_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    valid_d  = 1'b0;
    sh_d     = sh_q;
    rx_d     = rx_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    if (!active_q) begin
      if (trigger) begin
        active_d = 1'b1;
        phase_d  = 1'b0;
        sh_d     = data_in;
        mosi_d   = data_in[DATA_WIDTH-1];
        cnt_d    = '0;
      end
    end else if (!phase_q) begin
      // MISO sampled as SCLK rises; the slave changed it on the previous fall.
      sclk_d  = 1'b1;
      phase_d = 1'b1;
      rx_d    = {rx_q[DATA_WIDTH-2:0], miso};
    end else begin
      sclk_d  = 1'b0;
      phase_d = 1'b0;
      if (cnt_q == CW'(DATA_WIDTH-1)) begin
        active_d = 1'b0;
        valid_d  = 1'b1;
        dout_d   = rx_q;
        mosi_d   = 1'b1;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        sh_d   = {sh_q[DATA_WIDTH-2:0], 1'b0};
        mosi_d = sh_q[DATA_WIDTH-2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      valid_q  <= 1'b0;
      sh_q     <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      valid_q  <= valid_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = dout_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
endmodule

// File: rtl/sd_write.sv
// SD card single-sector write (CMD24) over SPI, sourcing 512 bytes from a byte RAM.
module sd_write
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int RAM_DEPTH    = RAM_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  sd_write_if.slave  bus,
  output logic       chip_data_out,
  output logic       chip_clk_out,
  output logic       chip_sel_out,
  input  logic       chip_data_in
);
  localparam int            AW   = $clog2(RAM_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH-1);

  sd_state_e     state_q, state_d;
  logic          wait_q, wait_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [15:0]   poll_q, poll_d;
  logic [31:0]   addr_q, addr_d;
  logic          trig_q, trig_d;
  logic [7:0]    tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [2:0]    code_q, code_d;
  logic          cs_q, cs_d;
  logic          ram_en_q, ram_en_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_vld_q, ram_vld_d;
  logic [7:0]    buf_q, buf_d;

  logic          spi_valid;
  logic [7:0]    spi_rx;
  logic [7:0]    tx_byte;
  logic [15:0]   poll_nxt;
  logic          issue, rx_done;

  spi_con #(.DATA_WIDTH(8)) u_spi (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trig_q),
    .data_in  (tx_q),
    .miso     (chip_data_in),
    .valid    (spi_valid),
    .data_out (spi_rx),
    .sclk     (chip_clk_out),
    .mosi     (chip_data_out)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    poll_d     = poll_q;
    addr_d     = addr_q;
    trig_d     = 1'b0;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    code_d     = code_q;
    cs_d       = cs_q;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_vld_d  = ram_en_q;
    buf_d      = ram_vld_q ? bus.ram_dout : buf_q;
    poll_nxt   = poll_q + 16'd1;

    case (state_q)
      ST_CMD:   tx_byte = cmd_byte(cnt_q[2:0], addr_q);
      ST_TOKEN: tx_byte = TOKEN_START;
      ST_DATA:  tx_byte = buf_q;
      default:  tx_byte = FILL_BYTE;
    endcase

    // Every sending state alternates: issue one byte, then wait for its valid.
    issue   = (state_q inside {ST_CMD, ST_R1_WAIT, ST_GAP, ST_TOKEN, ST_DATA,
                               ST_CRC, ST_DRESP, ST_BUSY}) && !wait_q;
    rx_done = wait_q && spi_valid;
    if (issue) begin
      trig_d = 1'b1;
      tx_d   = tx_byte;
      wait_d = 1'b1;
    end
    if (rx_done) wait_d = 1'b0;

    case (state_q)
      ST_IDLE: if (bus.write_en) begin
        state_d = ST_CMD;
        addr_d  = bus.addr_in;
        code_d  = ERR_NONE;
        busy_d  = 1'b1;
        cs_d    = 1'b0;
        cnt_d   = '0;
        wait_d  = 1'b0;
      end
      ST_CMD: if (rx_done) begin
        if (cnt_q == AW'(5)) begin
          state_d = ST_R1_WAIT;
          poll_d  = '0;
        end else cnt_d = cnt_q + AW'(1);
      end
      ST_R1_WAIT: if (rx_done) begin
        if (spi_rx != FILL_BYTE) begin
          if (spi_rx == 8'h00) state_d = ST_GAP;
          else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            code_d  = ERR_R1;
          end
        end else if (poll_nxt >= 16'(RESP_TIMEOUT)) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          code_d  = ERR_R1_TIMEOUT;
        end else poll_d = poll_nxt;
      end
      ST_GAP: if (rx_done) state_d = ST_TOKEN;
      ST_TOKEN: begin
        // Prefetch byte 0 while the start token shifts out.
        if (issue) begin
          ram_en_d   = 1'b1;
          ram_addr_d = '0;
        end
        if (rx_done) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (issue && cnt_q != LAST) begin
          ram_en_d   = 1'b1;
          ram_addr_d = cnt_q + AW'(1);
        end
        if (rx_done) begin
          if (cnt_q == LAST) begin
            state_d = ST_CRC;
            cnt_d   = '0;
          end else cnt_d = cnt_q + AW'(1);
        end
      end
      ST_CRC: if (rx_done) begin
        if (cnt_q == AW'(1)) state_d = ST_DRESP;
        else cnt_d = cnt_q + AW'(1);
      end
      ST_DRESP: if (rx_done) begin
        if (spi_rx[4:0] == DATA_ACCEPT) begin
          state_d = ST_BUSY;
          poll_d  = '0;
        end else begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          code_d  = ERR_DATA_REJ;
        end
      end
      ST_BUSY: if (rx_done) begin
        if (spi_rx != 8'h00) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (poll_nxt >= 16'(BUSY_TIMEOUT)) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          code_d  = ERR_BUSY_TIMEOUT;
        end else poll_d = poll_nxt;
      end
      ST_DONE, ST_ERROR: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= 1'b0;
      cnt_q      <= '0;
      poll_q     <= '0;
      addr_q     <= '0;
      trig_q     <= 1'b0;
      tx_q       <= FILL_BYTE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= ERR_NONE;
      cs_q       <= 1'b1;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_vld_q  <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      poll_q     <= poll_d;
      addr_q     <= addr_d;
      trig_q     <= trig_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      code_q     <= code_d;
      cs_q       <= cs_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      ram_vld_q  <= ram_vld_d;
      buf_q      <= buf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_code = code_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_addr = ram_addr_q;
  assign chip_sel_out = cs_q;
endmodule

// File: tb/tb_sd_write.sv
// Directed bench for sd_write: SD card model on the SPI pins, RAM model, vector table.
module tb_sd_write;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_write_if #(.RAM_DEPTH(512)) bus();
  logic mosi, sclk, cs;
  logic miso = 1'b1;

  sd_write #(.RESP_TIMEOUT(255), .BUSY_TIMEOUT(65535), .RAM_DEPTH(512)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .chip_data_out(mosi), .chip_clk_out(sclk), .chip_sel_out(cs), .chip_data_in(miso)
  );

  int errors = 0;
  int checks = 0;

  // Card scenario knobs
  int         sc_p = 3;
  logic [7:0] sc_r1 = 8'h00;
  bit         sc_silent = 1'b0;
  logic [7:0] sc_dresp = 8'hE5;
  int         sc_b = 10;

  function automatic logic [7:0] mem_val(input int i);
    return 8'((i * 37 + 5) ^ (i >> 8));
  endfunction

  function automatic logic [7:0] resp(input int i);
    int j;
    j = 6 + sc_p;
    if (sc_silent || i < j) return 8'hFF;
    if (i == j) return sc_r1;
    if (i == j + 517) return sc_dresp;
    if (i >= j + 518 && i < j + 518 + sc_b) return 8'h00;
    return 8'hFF;
  endfunction

  function automatic logic resp_bit(input int i, input int k);
    logic [7:0] r;
    r = resp(i);
    return r[k];
  endfunction

  function automatic logic [7:0] exp_mosi(input int i, input logic [31:0] a, input int p);
    int j;
    j = 6 + p;
    if (i == 0) return 8'h58;
    if (i >= 1 && i <= 4) return 8'(a >> (8 * (4 - i)));
    if (i <= j + 1) return 8'hFF;
    if (i == j + 2) return 8'hFE;
    if (i <= j + 514) return mem_val(i - j - 3);
    return 8'hFF;
  endfunction

  always @(posedge clk) if (bus.ram_en) bus.ram_dout <= mem_val(int'(bus.ram_addr));

  // Card model: samples MOSI on SCLK rise, shifts MISO on SCLK fall.
  int         nb = 0;
  int         bc = 0;
  logic [7:0] rxb = 8'h00;
  logic       sclk_p = 1'b0;
  logic       cs_p = 1'b1;
  logic [7:0] mlog [0:1023];
  always @(negedge clk) begin
    if (!cs && cs_p) begin
      nb <= 0; bc <= 0; miso <= resp_bit(0, 7);
    end else if (!cs) begin
      if (sclk && !sclk_p) begin
        rxb <= {rxb[6:0], mosi};
        bc  <= bc + 1;
      end else if (!sclk && sclk_p) begin
        if (bc == 8) begin
          if (nb < 1024) mlog[nb] <= rxb;
          nb   <= nb + 1;
          bc   <= 0;
          miso <= resp_bit(nb + 1, 7);
        end else miso <= resp_bit(nb, 7 - bc);
      end
    end
    sclk_p <= sclk;
    cs_p   <= cs;
  end

  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  always @(posedge clk) begin
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.error) err_cnt <= err_cnt + 1;
    if (bus.done && bus.error) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, 32'(bus.busy), 0);
    chk({pfx, "_done"}, 32'(bus.done), 0);
    chk({pfx, "_error"}, 32'(bus.error), 0);
    chk({pfx, "_err_code"}, 32'(bus.err_code), 0);
    chk({pfx, "_ram_en"}, 32'(bus.ram_en), 0);
    chk({pfx, "_ram_addr"}, 32'(bus.ram_addr), 0);
    chk({pfx, "_cs"}, 32'(cs), 1);
    chk({pfx, "_sclk"}, 32'(sclk), 0);
    chk({pfx, "_mosi"}, 32'(mosi), 1);
  endtask

  task automatic start(input logic [31:0] a);
    @(negedge clk);
    bus.addr_in  = a;
    bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
    chk("busy_rise", 32'(bus.busy), 1);
  endtask

  task automatic wait_end(input int d0, input int e0);
    bit fin;
    fin = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      @(posedge clk); #1;
      if (done_cnt != d0 || err_cnt != e0) begin fin = 1'b1; break; end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL end_wait: no done/error within 30000 cycles, got 0 expected 1");
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic chk_stream(input logic [31:0] a, input int p, input int n);
    int mm;
    mm = 0;
    for (int i = 0; i < n && i < 1024; i++) if (mlog[i] !== exp_mosi(i, a, p)) mm++;
    chk("mosi_stream_mismatches", 32'(mm), 0);
  endtask

  task automatic set_scn(input int p, input logic [7:0] r1, input bit sil,
                         input logic [7:0] dr, input int b);
    sc_p = p; sc_r1 = r1; sc_silent = sil; sc_dresp = dr; sc_b = b;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          p;
    logic [7:0]  r1;
    bit          silent;
    logic [7:0]  dresp;
    int          b;
    int          exp_done;
    int          exp_err;
    logic [2:0]  exp_code;
    int          exp_nb;
    bit          do_stream;
    bit          no_token;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0, e0, fe, w;
    bit hit;
    vecs[0] = '{32'h0000_0010, 3, 8'h00, 1'b0, 8'hE5, 10, 1, 0, 3'd0, 538, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0010, 3, 8'h04, 1'b0, 8'hE5, 10, 0, 1, 3'd2, 10,  1'b0, 1'b1};
    vecs[2] = '{32'h0000_0010, 3, 8'h00, 1'b1, 8'hE5, 10, 0, 1, 3'd1, 261, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0010, 3, 8'h00, 1'b0, 8'hEB, 10, 0, 1, 3'd3, 527, 1'b0, 1'b0};
    vecs[4] = '{32'hA1B2_C3D4, 0, 8'h00, 1'b0, 8'h05, 0,  1, 0, 3'd0, 525, 1'b1, 1'b0};

    bus.write_en = 1'b0;
    bus.addr_in  = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      set_scn(vecs[v].p, vecs[v].r1, vecs[v].silent, vecs[v].dresp, vecs[v].b);
      d0 = done_cnt; e0 = err_cnt;
      start(vecs[v].addr);
      wait_end(d0, e0);
      chk($sformatf("v%0d_done", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_err_code", v), 32'(bus.err_code), 32'(vecs[v].exp_code));
      chk($sformatf("v%0d_bytes", v), 32'(nb), 32'(vecs[v].exp_nb));
      chk($sformatf("v%0d_busy_low", v), 32'(bus.busy), 0);
      if (vecs[v].do_stream) chk_stream(vecs[v].addr, vecs[v].p, vecs[v].exp_nb);
      if (vecs[v].no_token) begin
        fe = 0;
        for (int i = 6; i < nb && i < 1024; i++) if (mlog[i] == 8'hFE) fe++;
        chk($sformatf("v%0d_no_token", v), 32'(fe), 0);
      end
    end

    // Asynchronous reset while data byte 100 is shifting.
    set_scn(3, 8'h00, 1'b0, 8'hE5, 10);
    d0 = done_cnt; e0 = err_cnt;
    start(32'h0000_0010);
    hit = 1'b0;
    for (w = 0; w < 20000; w++) begin
      @(posedge clk);
      if (nb == 112 && bc >= 3) begin hit = 1'b1; break; end
    end
    chk("reach_data_byte100", 32'(hit), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.addr_in  = 32'h0000_0010;
    bus.write_en = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    bus.write_en = 1'b0;
    chk("post_rst_accept", 32'(bus.busy), 1);
    wait_end(d0, e0);
    chk("post_rst_done", 32'(done_cnt - d0), 1);
    chk("post_rst_error", 32'(err_cnt - e0), 0);
    chk("post_rst_bytes", 32'(nb), 538);
    chk_stream(32'h0000_0010, 3, 538);

    // write_en during card busy is ignored.
    d0 = done_cnt; e0 = err_cnt;
    start(32'h0000_0010);
    hit = 1'b0;
    for (w = 0; w < 20000; w++) begin
      @(posedge clk);
      if (nb >= 530) begin hit = 1'b1; break; end
    end
    chk("reach_busy", 32'(hit), 1);
    @(negedge clk);
    bus.addr_in  = 32'hDEAD_BEEF;
    bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
    wait_end(d0, e0);
    chk("busy_we_done", 32'(done_cnt - d0), 1);
    chk("busy_we_error", 32'(err_cnt - e0), 0);
    chk("busy_we_bytes", 32'(nb), 538);
    chk_stream(32'h0000_0010, 3, 538);
    repeat (200) @(posedge clk);
    #1;
    chk("busy_we_idle_busy", 32'(bus.busy), 0);
    chk("busy_we_idle_cs", 32'(cs), 1);
    chk("busy_we_single_done", 32'(done_cnt - d0), 1);

    chk("done_error_exclusive", 32'(both_cnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
